// File: rtl/mmio_hal_bridge_if.sv
// ---------------------------------------------------------------------------
// mmio_hal_bridge_if
// Host-side MMIO request/response bundle for mmio_hal_bridge.
//   req_rd_valid / req_wr_valid : read / write request strobes (host -> bridge)
//   req_addr                    : request address, DWORD units
//   req_tid                     : read transaction ID
//   req_data                    : write data
//   rsp_valid / rsp_tid         : read response strobe and echoed ID (bridge -> host)
//   rsp_data                    : read response data, zero when rsp_valid is low
// Modports: master = host side, slave = bridge side.
// ---------------------------------------------------------------------------
interface mmio_hal_bridge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  req_rd_valid;
  logic                  req_wr_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [8:0]            req_tid;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [8:0]            rsp_tid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_rd_valid, req_wr_valid, req_addr, req_tid, req_data,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  req_rd_valid, req_wr_valid, req_addr, req_tid, req_data,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/mmio_hal_bridge.sv
// ---------------------------------------------------------------------------
// mmio_hal_bridge
// Bridges host MMIO requests onto a simple user register port with fixed
// latencies. Writes reach the user port one cycle after the request; reads
// issue rd_en one cycle after the request, sample rd_data two cycles after,
// and answer the host three cycles after. Accesses outside
// [START_ADDR, END_ADDR] never reach the user port, reads among them return
// zero, and each one bumps a saturating counter.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   host (slave modport)     : host request / response bundle
//   rd_en, rd_addr, rd_data  : user read port (rd_data valid the cycle after rd_en)
//   wr_en, wr_addr, wr_data  : user write port
//   oor_count                : saturating count of out-of-range accesses
// ---------------------------------------------------------------------------
module mmio_hal_bridge #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 'h0FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_hal_bridge_if.slave      host,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [15:0]           oor_count
);

  // Tag carried alongside each read through the pipeline; with no
  // backpressure a plain shift register keeps responses in issue order.
  typedef struct packed {
    logic       valid;
    logic [8:0] tid;
    logic       in_range;
  } rd_tag_t;

  rd_tag_t s1_tag;
  rd_tag_t s2_tag;

  // Range check by borrow bits of two subtractions: a borrow means the
  // address lies below START_ADDR or above END_ADDR. This avoids a
  // constant-true compare when START_ADDR is zero.
  logic [ADDR_WIDTH:0] below_diff;
  logic [ADDR_WIDTH:0] above_diff;
  logic                in_range;

  assign below_diff = {1'b0, host.req_addr} - {1'b0, START_ADDR};
  assign above_diff = {1'b0, END_ADDR} - {1'b0, host.req_addr};
  assign in_range   = !below_diff[ADDR_WIDTH] && !above_diff[ADDR_WIDTH];

  // Simultaneous out-of-range read and write add two in one cycle.
  logic        rd_oor;
  logic        wr_oor;
  logic [1:0]  oor_inc;
  logic [16:0] oor_sum;

  assign rd_oor  = host.req_rd_valid && !in_range;
  assign wr_oor  = host.req_wr_valid && !in_range;
  assign oor_inc = {1'b0, rd_oor} + {1'b0, wr_oor};
  assign oor_sum = {1'b0, oor_count} + {15'd0, oor_inc};

  // Stage S1: user strobes, addresses and the read tag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline stages shift together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      s1_tag    <= '0;
      oor_count <= '0;
    end else begin
      rd_en  <= host.req_rd_valid && in_range;
      wr_en  <= host.req_wr_valid && in_range;
      s1_tag <= '{valid: host.req_rd_valid, tid: host.req_tid, in_range: in_range};
      if (host.req_rd_valid && in_range) begin
        rd_addr <= host.req_addr;
      end
      if (host.req_wr_valid && in_range) begin
        wr_addr <= host.req_addr;
        wr_data <= host.req_data;
      end
      oor_count <= oor_sum[16] ? 16'hFFFF : oor_sum[15:0];
    end
  end

  // Stage S2 waits out the user read latency; stage S3 captures rd_data
  // and forms the response. Out-of-range reads and idle cycles yield zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_tag        <= '0;
      host.rsp_valid <= 1'b0;
      host.rsp_tid   <= '0;
      host.rsp_data  <= '0;
    end else begin
      s2_tag         <= s1_tag;
      host.rsp_valid <= s2_tag.valid;
      host.rsp_tid   <= s2_tag.valid ? s2_tag.tid : '0;
      host.rsp_data  <= (s2_tag.valid && s2_tag.in_range) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_mmio_hal_bridge.sv
// ---------------------------------------------------------------------------
// tb_mmio_hal_bridge
// Self-checking bench for mmio_hal_bridge. A scoreboard keyed by clock edge
// predicts user-port strobes, responses and the out-of-range count from the
// bridge's stated latencies; scenario tasks add their own targeted checks.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge (scoreboard) or on the falling edge (scenario tasks).
// ---------------------------------------------------------------------------
module tb_mmio_hal_bridge;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam logic [AW-1:0] START_A = 16'h0000;
  localparam logic [AW-1:0] END_A   = 16'h0FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;
  logic [15:0]   oor_count;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_hal_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mmio_hal_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(START_A), .END_ADDR(END_A)
  ) dut (
    .clk(clk), .rst(rst), .host(bus),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .oor_count(oor_count)
  );

  always #5 clk = ~clk;

  // User register contents seen by the read port.
  function automatic logic [63:0] user_val(input logic [15:0] a);
    if (a == 16'h0020) return 64'hBEEF;
    return {a, a ^ 16'h5A5A, ~a, a ^ 16'hC3C3};
  endfunction

  // User slave: one-cycle read latency, random junk when not being read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= user_val(rd_addr);
    else       rd_data <= {$urandom, $urandom};
  end

  // ------------------------- scoreboard ----------------------------------
  typedef struct { logic [15:0] addr; logic [63:0] data; } wr_exp_t;
  typedef struct { logic [8:0] tid; logic [63:0] data; } rsp_exp_t;

  wr_exp_t     exp_wr [int];
  logic [15:0] exp_rd [int];
  rsp_exp_t    exp_rsp[int];
  int          exp_oor  = 0;
  int          edge_cnt = 0;

  always @(posedge clk) begin
    int a, hits;
    logic inr;
    edge_cnt++;
    if (rst) begin
      exp_wr.delete(); exp_rd.delete(); exp_rsp.delete();
      exp_oor = 0;
    end else begin
      a    = int'(bus.req_addr);
      inr  = (a >= int'(START_A)) && (a <= int'(END_A));
      hits = 0;
      if (bus.req_wr_valid) begin
        if (inr) exp_wr[edge_cnt] = '{bus.req_addr, bus.req_data};
        else     hits++;
      end
      if (bus.req_rd_valid) begin
        if (inr) exp_rd[edge_cnt] = bus.req_addr;
        else     hits++;
        exp_rsp[edge_cnt + 2] = '{bus.req_tid, inr ? user_val(bus.req_addr) : 64'd0};
      end
      exp_oor = (exp_oor + hits > 65535) ? 65535 : exp_oor + hits;
    end
  end

  always @(posedge clk) begin
    int e;
    #1;
    e = edge_cnt;
    if (rst) begin
      n_checks++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 ||
          bus.rsp_tid !== '0 || bus.rsp_data !== '0 || oor_count !== '0) begin
        n_fail++;
        $display("FAIL sb_reset t=%0t: rd_en=%b wr_en=%b rsp_valid=%b oor=%h, want all zero",
                 $time, rd_en, wr_en, bus.rsp_valid, oor_count);
      end
    end else begin
      n_checks++;
      if (exp_wr.exists(e)) begin
        if (wr_en !== 1'b1 || wr_addr !== exp_wr[e].addr || wr_data !== exp_wr[e].data) begin
          n_fail++;
          $display("FAIL sb_write t=%0t: wr_en=%b addr=%h data=%h, want 1 %h %h",
                   $time, wr_en, wr_addr, wr_data, exp_wr[e].addr, exp_wr[e].data);
        end
        exp_wr.delete(e);
      end else if (wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_write_idle t=%0t: wr_en=%b, want 0", $time, wr_en);
      end

      n_checks++;
      if (exp_rd.exists(e)) begin
        if (rd_en !== 1'b1 || rd_addr !== exp_rd[e]) begin
          n_fail++;
          $display("FAIL sb_read_issue t=%0t: rd_en=%b addr=%h, want 1 %h",
                   $time, rd_en, rd_addr, exp_rd[e]);
        end
        exp_rd.delete(e);
      end else if (rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_read_idle t=%0t: rd_en=%b, want 0", $time, rd_en);
      end

      n_checks++;
      if (exp_rsp.exists(e)) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== exp_rsp[e].tid ||
            bus.rsp_data !== exp_rsp[e].data) begin
          n_fail++;
          $display("FAIL sb_response t=%0t: valid=%b tid=%h data=%h, want 1 %h %h",
                   $time, bus.rsp_valid, bus.rsp_tid, bus.rsp_data,
                   exp_rsp[e].tid, exp_rsp[e].data);
        end
        exp_rsp.delete(e);
      end else if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin
        n_fail++;
        $display("FAIL sb_response_idle t=%0t: valid=%b data=%h, want 0 0",
                 $time, bus.rsp_valid, bus.rsp_data);
      end

      n_checks++;
      if (oor_count !== 16'(exp_oor)) begin
        n_fail++;
        $display("FAIL sb_oor_count t=%0t: got %h, want %h", $time, oor_count, 16'(exp_oor));
      end
    end
  end

  // ------------------------- stimulus helpers ----------------------------
  task automatic idle();
    bus.req_rd_valid = 1'b0;
    bus.req_wr_valid = 1'b0;
    bus.req_addr     = '0;
    bus.req_tid      = '0;
    bus.req_data     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ------------------------- scenarios -----------------------------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_data !== '0 || oor_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rd_en=%b wr_en=%b rsp_valid=%b rsp_data=%h oor=%h, want zeros",
               rd_en, wr_en, bus.rsp_valid, bus.rsp_data, oor_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.req_wr_valid = 1'b1; bus.req_addr = 16'h0010; bus.req_data = 64'hDEAD;
    @(negedge clk);
    idle();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 16'h0010 || wr_data !== 64'hDEAD) begin
      n_fail++;
      $display("FAIL write_strobe: wr_en=%b addr=%h data=%h, want 1 0010 dead",
               wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL write_one_cycle: wr_en=%b, want 0", wr_en);
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    bus.req_rd_valid = 1'b1; bus.req_addr = 16'h0020; bus.req_tid = 9'd5;
    @(negedge clk);
    idle();
    n_checks++;
    if (rd_en !== 1'b1 || rd_addr !== 16'h0020) begin
      n_fail++;
      $display("FAIL read_issue: rd_en=%b addr=%h, want 1 0020", rd_en, rd_addr);
    end
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_gap: rd_en=%b rsp_valid=%b, want 0 0", rd_en, bus.rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 9'd5 || bus.rsp_data !== 64'hBEEF) begin
      n_fail++;
      $display("FAIL read_response: valid=%b tid=%0d data=%h, want 1 5 beef",
               bus.rsp_valid, bus.rsp_tid, bus.rsp_data);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin
      n_fail++;
      $display("FAIL read_response_end: valid=%b data=%h, want 0 0", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3 && i <= 6) begin
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 9'(i - 2) ||
            bus.rsp_data !== user_val(base + 16'(i - 3))) begin
          n_fail++;
          $display("FAIL b2b_response_%0d: valid=%b tid=%0d data=%h, want 1 %0d %h",
                   i - 3, bus.rsp_valid, bus.rsp_tid, bus.rsp_data, i - 2,
                   user_val(base + 16'(i - 3)));
        end
      end
      if (i == 7) begin
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_tail: valid=%b, want 0", bus.rsp_valid);
        end
      end
      if (i < 4) begin
        bus.req_rd_valid = 1'b1; bus.req_addr = base + 16'(i); bus.req_tid = 9'(i + 1);
      end else begin
        idle();
      end
    end
  endtask

  task automatic test_oor_read();
    do_reset();
    // Request presented for the first rising edge after reset release.
    bus.req_rd_valid = 1'b1; bus.req_addr = END_A + 16'd1; bus.req_tid = 9'd7;
    @(negedge clk);
    idle();
    n_checks++;
    if (rd_en !== 1'b0 || oor_count !== 16'd1) begin
      n_fail++;
      $display("FAIL oor_read_count: rd_en=%b oor=%0d, want 0 1", rd_en, oor_count);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 9'd7 || bus.rsp_data !== '0) begin
      n_fail++;
      $display("FAIL oor_read_response: valid=%b tid=%0d data=%h, want 1 7 0",
               bus.rsp_valid, bus.rsp_tid, bus.rsp_data);
    end
  endtask

  task automatic test_simultaneous();
    // oor_count is 1 on entry.
    @(negedge clk);
    bus.req_rd_valid = 1'b1; bus.req_wr_valid = 1'b1;
    bus.req_addr = END_A; bus.req_tid = 9'h1FF; bus.req_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1 || wr_en !== 1'b1 || wr_addr !== END_A || rd_addr !== END_A ||
        oor_count !== 16'd1) begin
      n_fail++;
      $display("FAIL simul_in_range: rd_en=%b wr_en=%b rd_addr=%h wr_addr=%h oor=%0d, want 1 1 0fff 0fff 1",
               rd_en, wr_en, rd_addr, wr_addr, oor_count);
    end
    bus.req_addr = END_A + 16'd1; bus.req_tid = 9'h100;
    @(negedge clk);
    idle();
    n_checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || oor_count !== 16'd3) begin
      n_fail++;
      $display("FAIL simul_oor: rd_en=%b wr_en=%b oor=%0d, want 0 0 3", rd_en, wr_en, oor_count);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 9'h1FF || bus.rsp_data !== user_val(END_A)) begin
      n_fail++;
      $display("FAIL simul_rsp_in_range: valid=%b tid=%h data=%h, want 1 1ff %h",
               bus.rsp_valid, bus.rsp_tid, bus.rsp_data, user_val(END_A));
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 9'h100 || bus.rsp_data !== '0) begin
      n_fail++;
      $display("FAIL simul_rsp_oor: valid=%b tid=%h data=%h, want 1 100 0",
               bus.rsp_valid, bus.rsp_tid, bus.rsp_data);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    bus.req_rd_valid = 1'b1; bus.req_addr = 16'h0040; bus.req_tid = 9'd9;
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || bus.rsp_valid !== 1'b0 || rd_addr !== '0 ||
        bus.rsp_tid !== '0 || bus.rsp_data !== '0 || oor_count !== '0) begin
      n_fail++;
      $display("FAIL inflight_async_clear: rd_en=%b rsp_valid=%b rd_addr=%h oor=%h, want zeros",
               rd_en, bus.rsp_valid, rd_addr, oor_count);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin
        n_fail++;
        $display("FAIL inflight_dropped_%0d: valid=%b data=%h, want 0 0",
                 i, bus.rsp_valid, bus.rsp_data);
      end
    end
  endtask

  task automatic test_random();
    int events = 0;
    logic inr;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bus.req_rd_valid = 1'($urandom_range(0, 1));
      bus.req_wr_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       bus.req_addr = START_A;
        1:       bus.req_addr = END_A;
        2:       bus.req_addr = END_A + 16'd1;
        3:       bus.req_addr = 16'hFFFF;
        4:       bus.req_addr = 16'($urandom_range(0, int'(END_A)));
        default: bus.req_addr = 16'($urandom);
      endcase
      bus.req_tid  = 9'($urandom);
      bus.req_data = {$urandom, $urandom};
      inr = int'(bus.req_addr) <= int'(END_A);
      if (!inr) events += int'(bus.req_rd_valid) + int'(bus.req_wr_valid);
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (oor_count !== 16'(events)) begin
      n_fail++;
      $display("FAIL random_oor_total: got %0d, want %0d", oor_count, events);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      if (i == 65534) begin
        n_checks++;
        if (oor_count !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL sat_before: got %h, want fffe", oor_count);
        end
      end
      if (i == 65536) begin
        n_checks++;
        if (oor_count !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL sat_reached: got %h, want ffff", oor_count);
        end
      end
      bus.req_wr_valid = 1'b1;
      bus.req_addr     = 16'($urandom_range(int'(END_A) + 1, 16'hFFFF));
      bus.req_data     = {$urandom, $urandom};
      @(negedge clk);
    end
    n_checks++;
    if (oor_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_65537: got %h, want ffff", oor_count);
    end
    bus.req_rd_valid = 1'b1; bus.req_addr = 16'hFFFF; bus.req_tid = 9'd3;
    @(negedge clk);
    idle();
    n_checks++;
    if (oor_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_double: got %h, want ffff", oor_count);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_oor_read();
    test_simultaneous();
    test_reset_inflight();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
